// File: rtl/leb128_decoder.sv
`default_nettype none
// ============================================================================
// Module   : leb128_decoder
// Purpose  : Byte-serial LEB128 immediate decoder for the wasm CPU front end.
//            Accepts one encoded byte per cycle and produces a WIDTH-bit
//            signed or unsigned value. Over-long encodings are reported as
//            trap=1 (TOO_LONG). With strict checking enabled, overflowing
//            final bytes are also reported, as trap=2 (OVERFLOW).
// Config   : `define LEB128_STRICT_EN enables the final-byte overflow check.
//            When it is undefined, excess bits are silently truncated.
// Ports    : clk        - clock, rising edge
//            reset      - asynchronous active-low reset
//            start      - begin a decode (sampled in IDLE only)
//            is_signed  - decode mode, latched with start
//            in_valid / in_ready / in_byte   - encoded byte stream
//            out_valid / out_ready           - result handshake
//            out_value  - decoded value
//            out_len    - bytes consumed (1..MAXB)
//            trap       - 0 none, 1 TOO_LONG, 2 OVERFLOW
// Revision : 1.0 - initial release
// ============================================================================
module leb128_decoder #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic             in_valid,
    input  logic [7:0]       in_byte,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_value,
    output logic [3:0]       out_len,
    output logic [1:0]       trap
);

    localparam int MAXB = (WIDTH + 6) / 7;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ACCUM = 2'd1;
    localparam logic [1:0] c_DONE  = 2'd2;

    localparam logic [3:0] c_LAST_IDX = 4'(MAXB - 1);

    localparam logic [1:0] c_TRAP_NONE     = 2'd0;
    localparam logic [1:0] c_TRAP_TOO_LONG = 2'd1;
    localparam logic [1:0] c_TRAP_OVERFLOW = 2'd2;

    logic [1:0]       r_state;
    logic             r_signed;
    logic [3:0]       r_k;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_value;
    logic [3:0]       r_len;
    logic [1:0]       r_trap;

    logic [6:0]       w_shamt;
    logic [6:0]       w_shamt_nxt;
    logic [WIDTH-1:0] w_payload;
    logic [WIDTH-1:0] w_acc_nxt;
    logic [WIDTH-1:0] w_sext_mask;
    logic [WIDTH-1:0] w_result;
    logic [1:0]       w_trap;
    logic             w_at_last;
    logic             w_final;
    logic             w_too_long;
    logic             w_sext;
    logic             w_ovf;

    // Bit offset of the current byte's payload, and of the first bit above it.
    assign w_shamt     = 7'(r_k) * 7'd7;
    assign w_shamt_nxt = w_shamt + 7'd7;

    // Shifting a WIDTH-wide vector drops payload bits that land at or above
    // WIDTH, which is exactly the truncation wanted for the last byte.
    assign w_payload = {{(WIDTH-7){1'b0}}, in_byte[6:0]};
    assign w_acc_nxt = r_acc | (w_payload << w_shamt);

    assign w_at_last  = (r_k == c_LAST_IDX);
    assign w_final    = !in_byte[7] || w_at_last;
    assign w_too_long = in_byte[7] && w_at_last;

    // The mask collapses to zero once 7(k+1) reaches WIDTH, so no extension
    // happens when the final byte already fills the top of the word.
    assign w_sext      = r_signed && in_byte[6];
    assign w_sext_mask = {WIDTH{1'b1}} << w_shamt_nxt;

`ifdef LEB128_STRICT_EN
    localparam int LASTBITS = WIDTH - 7 * (MAXB - 1);

    // Bits of the final byte beyond the word must be pure zero (unsigned)
    // or a copy of the top usable payload bit (signed).
    always_comb begin
        w_ovf = 1'b0;
        if (w_at_last && !in_byte[7]) begin
            if (r_signed)
                w_ovf = (in_byte[6:LASTBITS] != {(7-LASTBITS){in_byte[LASTBITS-1]}});
            else
                w_ovf = (in_byte[6:LASTBITS] != '0);
        end
    end
`else
    assign w_ovf = 1'b0;
`endif

    always_comb begin
        w_result = w_acc_nxt | (w_sext ? w_sext_mask : '0);
        w_trap   = c_TRAP_NONE;
        if (w_too_long) begin
            w_result = '0;
            w_trap   = c_TRAP_TOO_LONG;
        end else if (w_ovf) begin
            w_result = '0;
            w_trap   = c_TRAP_OVERFLOW;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= c_IDLE;
            r_signed <= 1'b0;
            r_k      <= 4'd0;
            r_acc    <= '0;
            r_value  <= '0;
            r_len    <= 4'd0;
            r_trap   <= c_TRAP_NONE;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_signed <= is_signed;
                        r_acc    <= '0;
                        r_k      <= 4'd0;
                        r_state  <= c_ACCUM;
                    end
                end
                c_ACCUM: begin
                    if (in_valid) begin
                        r_acc <= w_acc_nxt;
                        r_k   <= r_k + 4'd1;
                        if (w_final) begin
                            r_value <= w_result;
                            r_len   <= r_k + 4'd1;
                            r_trap  <= w_trap;
                            r_state <= c_DONE;
                        end
                    end
                end
                c_DONE: begin
                    if (out_ready)
                        r_state <= c_IDLE;
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == c_ACCUM);
    assign out_valid = (r_state == c_DONE);
    assign out_value = r_value;
    assign out_len   = r_len;
    assign trap      = r_trap;

endmodule
`default_nettype wire

// File: tb/tb_leb128_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_leb128_decoder
// Purpose  : Scoreboard bench for leb128_decoder. A 32-bit and a 64-bit
//            instance share one stimulus path selected by sel64. Stimulus
//            pushes expected results into per-instance queues; monitors pop
//            and compare whenever a result is handed over.
// Revision : 1.0 - initial release
// ============================================================================
module tb_leb128_decoder;

    typedef struct {
        logic [63:0] v;
        logic [3:0]  l;
        logic [1:0]  t;
    } exp_t;

    exp_t q32[$];
    exp_t q64[$];

    int checks = 0;
    int errors = 0;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic sel64 = 1'b0;
    logic start_r = 1'b0;
    logic sig_r = 1'b0;
    logic in_valid_r = 1'b0;
    logic [7:0] in_byte_r = 8'h00;
    logic out_ready_r = 1'b1;

    logic start32, start64, iv32, iv64;
    logic ir32, ir64, ov32, ov64;
    logic [31:0] val32;
    logic [63:0] val64;
    logic [3:0]  len32, len64;
    logic [1:0]  trap32, trap64;
    logic ir_m, ov_m;

    assign start32 = start_r && !sel64;
    assign start64 = start_r && sel64;
    assign iv32    = in_valid_r && !sel64;
    assign iv64    = in_valid_r && sel64;
    assign ir_m    = sel64 ? ir64 : ir32;
    assign ov_m    = sel64 ? ov64 : ov32;

    always #5 clk = ~clk;

    leb128_decoder #(.WIDTH(32)) u_dut32 (
        .clk(clk), .reset(reset), .start(start32), .is_signed(sig_r),
        .in_valid(iv32), .in_byte(in_byte_r), .in_ready(ir32),
        .out_valid(ov32), .out_ready(out_ready_r), .out_value(val32),
        .out_len(len32), .trap(trap32)
    );

    leb128_decoder #(.WIDTH(64)) u_dut64 (
        .clk(clk), .reset(reset), .start(start64), .is_signed(sig_r),
        .in_valid(iv64), .in_byte(in_byte_r), .in_ready(ir64),
        .out_valid(ov64), .out_ready(out_ready_r), .out_value(val64),
        .out_len(len64), .trap(trap64)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitors: a result is consumed when valid and ready meet.
    always @(negedge clk) begin
        if (ov32 && out_ready_r) begin
            if (q32.size() == 0) begin
                chk("unexpected_out32", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = q32.pop_front();
                chk("value32", {32'd0, val32}, e.v);
                chk("len32", {60'd0, len32}, {60'd0, e.l});
                chk("trap32", {62'd0, trap32}, {62'd0, e.t});
            end
        end
    end

    always @(negedge clk) begin
        if (ov64 && out_ready_r) begin
            if (q64.size() == 0) begin
                chk("unexpected_out64", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = q64.pop_front();
                chk("value64", val64, e.v);
                chk("len64", {60'd0, len64}, {60'd0, e.l});
                chk("trap64", {62'd0, trap64}, {62'd0, e.t});
            end
        end
    end

    // One decode: bytes are packed LSB-first (byte 0 in bits [7:0]).
    task automatic run(input bit d64, input bit s, input logic [79:0] bytes, input int n,
                       input logic [63:0] ev, input logic [3:0] el, input logic [1:0] et,
                       input bit hold);
        exp_t e;
        int cnt;
        e.v = ev; e.l = el; e.t = et;
        sel64 = d64;
        sig_r = s;
        if (d64) q64.push_back(e); else q32.push_back(e);
        start_r = 1'b1;
        @(posedge clk); #1;
        start_r = 1'b0;
        sig_r = ~s;  // latched value must be the one used
        for (int i = 0; i < n; i++) begin
            in_valid_r = 1'b1;
            in_byte_r  = bytes[8*i +: 8];
            cnt = 0;
            while (!ir_m && cnt < 20) begin
                @(posedge clk); #1;
                cnt++;
            end
            if (cnt >= 20) chk("in_ready_timeout", 64'd0, 64'd1);
            @(posedge clk); #1;
        end
        in_valid_r = 1'b0;
        chk("latency_valid", {63'd0, ov_m}, 64'd1);
        chk("done_in_ready", {63'd0, ir_m}, 64'd0);
        if (!hold) begin
            cnt = 0;
            while (ov_m && cnt < 20) begin
                @(posedge clk); #1;
                cnt++;
            end
            if (cnt >= 20) chk("out_valid_timeout", 64'd0, 64'd1);
        end
    endtask

    initial begin
        #12;
        // Reset state (reset still asserted low)
        chk("rst_out_valid", {63'd0, ov32}, 64'd0);
        chk("rst_in_ready", {63'd0, ir32}, 64'd0);
        chk("rst_out_value", {32'd0, val32}, 64'd0);
        chk("rst_out_len", {60'd0, len32}, 64'd0);
        chk("rst_trap", {62'd0, trap32}, 64'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        run(0, 0, 80'h26_8E_E5, 3, 64'h0009_8765, 4'd3, 2'd0, 0);
        run(0, 1, 80'h78_BB_C0, 3, 64'hFFFE_1DC0, 4'd3, 2'd0, 0);
        run(0, 1, 80'h7F, 1, 64'hFFFF_FFFF, 4'd1, 2'd0, 0);
        run(0, 0, 80'h80_80_80_80_80, 5, 64'h0, 4'd5, 2'd1, 0);
`ifdef LEB128_STRICT_EN
        run(0, 0, 80'h1F_FF_FF_FF_FF, 5, 64'h0, 4'd5, 2'd2, 0);
`else
        run(0, 0, 80'h1F_FF_FF_FF_FF, 5, 64'hFFFF_FFFF, 4'd5, 2'd0, 0);
`endif
        run(0, 0, 80'h0F_FF_FF_FF_FF, 5, 64'hFFFF_FFFF, 4'd5, 2'd0, 0);
        run(1, 0, 80'h01_FF_FF_FF_FF_FF_FF_FF_FF_FF, 10, 64'hFFFF_FFFF_FFFF_FFFF, 4'd10, 2'd0, 0);
        run(1, 1, 80'h7F, 1, 64'hFFFF_FFFF_FFFF_FFFF, 4'd1, 2'd0, 0);
        run(1, 0, 80'h80_80_80_80_80_80_80_80_80_80, 10, 64'h0, 4'd10, 2'd1, 0);

        // Backpressure: result held, start ignored while DONE.
        out_ready_r = 1'b0;
        run(0, 0, 80'h05, 1, 64'h5, 4'd1, 2'd0, 1);
        for (int i = 0; i < 5; i++) begin
            start_r = 1'b1;
            chk("bp_out_valid", {63'd0, ov32}, 64'd1);
            chk("bp_out_value", {32'd0, val32}, 64'h5);
            chk("bp_in_ready", {63'd0, ir32}, 64'd0);
            @(posedge clk); #1;
        end
        start_r = 1'b0;
        out_ready_r = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", {63'd0, ov32}, 64'd0);
        chk("bp_release_idle", {63'd0, ir32}, 64'd0);

        // Reset mid-decode: partial result discarded.
        sel64 = 1'b0;
        start_r = 1'b1;
        @(posedge clk); #1;
        start_r = 1'b0;
        in_valid_r = 1'b1;
        in_byte_r = 8'h80;
        @(posedge clk); #1;
        @(posedge clk); #1;
        in_valid_r = 1'b0;
        reset = 1'b0;
        #1;
        chk("midrst_out_valid", {63'd0, ov32}, 64'd0);
        chk("midrst_in_ready", {63'd0, ir32}, 64'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("midrst_idle", {63'd0, ir32}, 64'd0);
        run(0, 0, 80'h2A, 1, 64'd42, 4'd1, 2'd0, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("q32_drained", 64'(q32.size()), 64'd0);
        chk("q64_drained", 64'(q64.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/leb128_decoder.md
Name: leb128_decoder

Overview:
- Byte-serial LEB128 immediate decoder for the wasm CPU front end. Sits between the instruction byte fetch path and the operand stack.
- Decodes a signed or unsigned LEB128 operand into a WIDTH-bit value, one byte per cycle, with valid/ready handshakes on both sides.
- Detects over-long and overflowing encodings and reports them as traps, so the CPU can raise them exactly as it does for other execution faults.

Parameters:
- WIDTH, 64, decoded value width; legal values 32 or 64.
- MAXB, (WIDTH+6)/7, derived: maximum encoded bytes (5 for 32, 10 for 64).
- LASTBITS, WIDTH-7*(MAXB-1), derived: payload bits usable in byte MAXB-1 (4 for 32, 1 for 64).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  begin a new decode; sampled only in IDLE.
- is_signed  in  1  decode mode; latched when start is accepted.
- in_valid  in  1  in_byte is valid.
- in_byte  in  8  encoded byte; bit7 is the continuation bit, bits[6:0] are payload.
- in_ready  out  1  decoder accepts a byte this cycle.
- out_valid  out  1  result (or trap) is available.
- out_ready  in  1  consumer takes the result.
- out_value  out  WIDTH  decoded value.
- out_len  out  4  number of bytes consumed (1..MAXB).
- trap  out  2  0 = none, 1 = TOO_LONG, 2 = OVERFLOW.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; in_ready, out_valid, out_value, out_len, trap all 0; accumulator and byte index cleared. Takes effect mid-decode; the partial result is discarded.
- States: IDLE, ACCUM, DONE.
- IDLE:
  - in_ready=0.
  - start=1 latches is_signed, clears the accumulator and sets index k=0, then moves to ACCUM.
- ACCUM:
  - in_ready=1.
  - Each handshake (in_valid & in_ready) ORs in_byte[6:0] into accumulator bits [7k+6:7k]; bits at or above WIDTH are dropped. It then increments k.
  - If bit7=0, or bit7=1 with k=MAXB-1: register the result and move to DONE. out_valid rises the cycle after the final byte's handshake (latency 1 cycle).
  - start is ignored in ACCUM and DONE.
- Sign extension: when is_signed=1, the terminating byte is at index k, in_byte[6]=1 and 7(k+1) < WIDTH, bits [WIDTH-1:7(k+1)] are set to 1. Unsigned decodes zero-fill.
- TOO_LONG: byte index MAXB-1 arrives with bit7=1. Result is out_value=0, trap=1, out_len=MAXB. No further bytes are consumed.
- DONE:
  - out_valid=1; out_value, out_len and trap are held stable.
  - out_ready=1 returns to IDLE the next cycle; out_valid drops in that same next cycle.
  - in_ready=0.
- Back-to-back: start may be asserted in the first IDLE cycle after DONE; there are no hidden idle cycles.
- Simultaneous reset with any handshake: reset wins.

Optional Feature:
- Macro: LEB128_STRICT_EN.
- Defined:
  - The terminating byte at index MAXB-1 is checked for overflow. Unsigned: bits [6:LASTBITS] must be 0. Signed: bits [6:LASTBITS] must all equal bit LASTBITS-1.
  - Violation gives out_value=0, trap=2, out_len=MAXB.
- Undefined: excess bits are silently truncated, and trap=2 is never produced.

Test Plan:
- WIDTH=32, unsigned, bytes E5 8E 26 → out_value=0x00098765 (624485), out_len=3, trap=0, out_valid one cycle after the 0x26 handshake.
- WIDTH=32, signed, bytes C0 BB 78 → out_value=0xFFFE1DC0 (-123456), out_len=3. Separately, signed single byte 7F → 0xFFFFFFFF, out_len=1.
- WIDTH=32, unsigned, bytes 80 80 80 80 80 → trap=1, out_value=0, out_len=5, in_ready=0 after the 5th byte. WIDTH=64, unsigned, bytes FF×9 then 01 → 0xFFFFFFFFFFFFFFFF, out_len=10.
- WIDTH=32, unsigned, bytes FF FF FF FF 1F:
  - With LEB128_STRICT_EN → trap=2, out_value=0.
  - Without it → 0xFFFFFFFF, trap=0.
  - FF FF FF FF 0F → 0xFFFFFFFF, trap=0 in both builds.
- Backpressure: hold out_ready=0 for 5 cycles → out_valid and out_value stable, in_ready=0, start ignored. Then out_ready=1 → IDLE next cycle.
- Reset mid-decode: after bytes 80 80 are accepted, pulse reset low for 1 cycle → out_valid=0, in_ready=0, state IDLE. A new start then decodes 2A → 42, out_len=1.
